y86_fetch: RTL and testbench
============================

// Module: y86_fetch
// PURPOSE
//  Fetch stage directly upstream of the y86 instruction memory: owns the PC,
//  drives the IRAM byte address, and splits the returned 6-byte little-endian
//  window into icode/ifun/rA/rB/valC. Computes valP and predicts the next PC.
//  Captures the result in the F/D pipeline register consumed by decode.
// PARAMETERS
//  RESET_PC  32'h0  PC loaded on reset
//  MEM_SIZE  4096   IRAM size in bytes; fetches past it raise ADR
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  stall        in   1   hold PC and F/D register
//  bubble       in   1   load NOP bubble into F/D register
//  redirect     in   1   later stage corrects PC (mispredict / ret target)
//  redirect_pc  in   32  corrected PC
//  iaddr        out  32  IRAM byte address (= PC, combinational)
//  idata        in   48  IRAM bytes {b5..b0}, b0 = idata[7:0]
//  d_valid      out  1   F/D holds a real instruction
//  d_icode      out  4   instruction code
//  d_ifun       out  4   function code
//  d_rA, d_rB   out  4   register ids, 4'hF (RNONE) when no register byte
//  d_valC       out  32  constant, 0 when absent
//  d_valP       out  32  PC + instruction length
//  d_pc         out  32  PC of this instruction
//  d_stat       out  3   AOK=1 HLT=2 ADR=3 INS=4
//  fetch_state  out  2   FSM state, for debug/bench
// BEHAVIOUR
//  Reset: PC=RESET_PC, state RUN, F/D = bubble (d_valid=0, d_icode=1 NOP,
//   ifun=0, rA=rB=F, valC=0, valP=0, d_pc=0, d_stat=AOK).
//  Decode of b0: icode=b0[7:4], ifun=b0[3:0]. Lengths: 0,1,9 -> 1;
//   2,6,A,B -> 2 (rA/rB=b1); 3,4,5 -> 6 (rA/rB=b1, valC={b5,b4,b3,b2});
//   7,8 -> 5 (valC={b4,b3,b2,b1}). icode C..F -> INS, length 1.
//  valP = PC + len, 32-bit, wraps modulo 2^32.
//  ADR when PC + len > MEM_SIZE (compare in 33 bits); ADR overrides INS.
//  Next-PC prediction: jXX/call -> valC; others -> valP.
//  FSM (updates only when the stage advances):
//   RUN:      fetch; halt -> HALT; ret -> WAIT_RET; INS/ADR -> ERR.
//   WAIT_RET: PC frozen, F/D loads bubbles each cycle until redirect.
//   HALT/ERR: PC frozen, F/D loads bubbles; the halting/faulting instruction
//             itself is latched once with its stat (HLT/INS/ADR).
//   redirect from any state: PC<=redirect_pc, state<=RUN, F/D<=bubble.
//  Priority per cycle: reset > redirect > stall/bubble > normal fetch.
//   stall=1: PC, state, F/D hold. bubble=1: F/D <= bubble.
//   stall=1 and bubble=1: PC/state hold, F/D <= bubble.
//   The redirect cycle itself latches no instruction (1-cycle penalty).
//  Latency: instruction at PC appears on d_* one cycle after iaddr=PC.
//  Reset asserted mid-operation discards everything on the same edge.
// STRUCTURE
//  y86_pkg: icode constants (HALT..POPL), stat codes, RNONE, FSM state enum.
//  Sub-module y86_ilen: combinational icode -> {len, need_regs, need_valC, ok}.
//  Top: PC register, FSM, F/D register, ADR compare, next-PC mux.
// TESTING
//  1 Reset, IRAM: 30 F2 78 56 34 12 (irmovl) -> d_icode=3 rB=2 valC=12345678
//    valP=6; next iaddr=6.
//  2 jmp 70 20 00 00 00 at PC 0 -> d_valC=0x20, d_valP=5, next iaddr=0x20.
//  3 ret (90) at PC 8 -> WAIT_RET, bubbles, iaddr stays 9; redirect_pc=0x40
//    -> iaddr=0x40, RUN, next d_pc=0x40.
//  4 Byte F0 at PC 4 -> d_stat=INS, state ERR, following F/D all bubbles,
//    iaddr frozen; halt (00) same pattern with HLT/HALT.
//  5 irmovl at PC=MEM_SIZE-4 -> d_stat=ADR, ERR; at MEM_SIZE-6 -> AOK.
//  6 stall 3 cycles mid-stream -> d_* and iaddr unchanged; stall+bubble ->
//    d_valid=0, iaddr unchanged; redirect+stall same cycle -> redirect wins.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared y86 fetch definitions: instruction codes, status codes, register
// sentinel, fetch FSM states and the F/D pipeline register layout.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_RET = 2'd1,
        S_HALT     = 2'd2,
        S_ERR      = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] valc;
        logic [31:0] valp;
        logic [31:0] pc;
        logic [2:0]  stat;
    } fd_t;

    // A bubble is a NOP that decode must ignore.
    function automatic fd_t fd_bubble();
        fd_t b;
        b.valid = 1'b0;
        b.icode = I_NOP;
        b.ifun  = 4'h0;
        b.ra    = RNONE;
        b.rb    = RNONE;
        b.valc  = 32'h0;
        b.valp  = 32'h0;
        b.pc    = 32'h0;
        b.stat  = STAT_AOK;
        return b;
    endfunction

endpackage

// File: rtl/y86_fetch_ilen.sv
// Combinational instruction-length decoder: icode -> length, whether a
// register byte and/or a 32-bit constant follow, and whether icode is legal.
module y86_ilen
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [2:0] len,
    output logic       need_regs,
    output logic       need_valc,
    output logic       ok
);

    always_comb begin
        len       = 3'd1;
        need_regs = 1'b0;
        need_valc = 1'b0;
        ok        = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL: begin
                len       = 3'd2;
                need_regs = 1'b1;
            end
            I_IRMOVL, I_RMMOVL, I_MRMOVL: begin
                len       = 3'd6;
                need_regs = 1'b1;
                need_valc = 1'b1;
            end
            I_JXX, I_CALL: begin
                len       = 3'd5;
                need_valc = 1'b1;
            end
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_fetch.sv
// y86 fetch stage: owns the PC, splits the IRAM window into instruction
// fields, predicts the next PC and fills the F/D register for decode.
module y86_fetch
    import y86_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        bubble,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] iaddr,
    input  logic [47:0] idata,
    output logic        d_valid,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [3:0]  d_rA,
    output logic [3:0]  d_rB,
    output logic [31:0] d_valC,
    output logic [31:0] d_valP,
    output logic [31:0] d_pc,
    output logic [2:0]  d_stat,
    output logic [1:0]  fetch_state
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    logic [31:0]  pc, pc_next, valp, pred_pc;
    fetch_state_t state, state_next;
    fd_t          fd, fd_next, fetched;
    logic [2:0]   len;
    logic         need_regs, need_valc, ok, adr;

    y86_ilen u_ilen (
        .icode    (idata[7:4]),
        .len      (len),
        .need_regs(need_regs),
        .need_valc(need_valc),
        .ok       (ok)
    );

    assign valp = pc + {29'b0, len};
    // Range check in 33 bits so a PC near the top of the address space faults.
    assign adr  = ({1'b0, pc} + {30'b0, len}) > MEM_LIMIT;

    always_comb begin
        fetched.valid = 1'b1;
        fetched.icode = idata[7:4];
        fetched.ifun  = idata[3:0];
        fetched.ra    = need_regs ? idata[15:12] : RNONE;
        fetched.rb    = need_regs ? idata[11:8]  : RNONE;
        fetched.valc  = 32'h0;
        if (need_valc)
            fetched.valc = need_regs ? idata[47:16] : idata[39:8];
        fetched.valp  = valp;
        fetched.pc    = pc;
        if (adr)
            fetched.stat = STAT_ADR;
        else if (!ok)
            fetched.stat = STAT_INS;
        else if (idata[7:4] == I_HALT)
            fetched.stat = STAT_HLT;
        else
            fetched.stat = STAT_AOK;
    end

    assign pred_pc = (fetched.icode == I_JXX || fetched.icode == I_CALL) ?
                     fetched.valc : valp;

    // The stage only advances when neither stalled nor bubbled; any held-off
    // fetch is simply retried from the same PC.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        fd_next    = fd;
        if (redirect) begin
            pc_next    = redirect_pc;
            state_next = S_RUN;
            fd_next    = fd_bubble();
        end else if (stall) begin
            if (bubble)
                fd_next = fd_bubble();
        end else if (bubble) begin
            fd_next = fd_bubble();
        end else if (state == S_RUN) begin
            fd_next = fetched;
            pc_next = pred_pc;
            case (fetched.stat)
                STAT_ADR, STAT_INS: state_next = S_ERR;
                STAT_HLT:           state_next = S_HALT;
                default:            state_next = (fetched.icode == I_RET) ?
                                                 S_WAIT_RET : S_RUN;
            endcase
        end else begin
            fd_next = fd_bubble();
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= S_RUN;
            fd    <= fd_bubble();
        end else begin
            pc    <= pc_next;
            state <= state_next;
            fd    <= fd_next;
        end
    end

    assign iaddr       = pc;
    assign fetch_state = state;
    assign d_valid     = fd.valid;
    assign d_icode     = fd.icode;
    assign d_ifun      = fd.ifun;
    assign d_rA        = fd.ra;
    assign d_rB        = fd.rb;
    assign d_valC      = fd.valc;
    assign d_valP      = fd.valp;
    assign d_pc        = fd.pc;
    assign d_stat      = fd.stat;

endmodule

// File: tb/tb_y86_fetch.sv
// Bench for y86_fetch: directed scenarios plus randomized control/memory,
// compared every cycle against a table-driven behavioural fetch model.
module tb_y86_fetch;
    import y86_pkg::*;

    localparam int          MEM_SIZE = 4096;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, bubble = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] iaddr;
    logic [47:0] idata;
    logic        d_valid;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [31:0] d_valC, d_valP, d_pc;
    logic [2:0]  d_stat;
    logic [1:0]  fetch_state;

    logic [7:0]  mem [MEM_SIZE];
    int          testCount = 0;
    int          failCount = 0;

    // Instruction length by icode; 0 marks an illegal icode.
    int lenTable [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 0, 0, 0, 0};

    logic [31:0]  mpc;
    fetch_state_t mmode;
    logic         eValid;
    logic [3:0]   eIcode, eIfun, eRa, eRb;
    logic [31:0]  eValc, eValp, ePc;
    logic [2:0]   eStat;

    y86_fetch #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
        .redirect(redirect), .redirect_pc(redirect_pc), .iaddr(iaddr),
        .idata(idata), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
        .d_pc(d_pc), .d_stat(d_stat), .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rdByte(input logic [31:0] a);
        return (a < 32'(MEM_SIZE)) ? mem[a[11:0]] : 8'h00;
    endfunction

    always_comb begin
        idata = '0;
        for (int k = 0; k < 6; k++)
            idata[k*8 +: 8] = rdByte(iaddr + 32'(k));
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic putBytes(input int addr, input logic [47:0] bytes, input int n);
        for (int k = 0; k < n; k++)
            if (addr + k < MEM_SIZE)
                mem[addr + k] = bytes[k*8 +: 8];
    endtask

    task automatic modelBubble();
        eValid = 1'b0; eIcode = 4'h1; eIfun = 4'h0; eRa = 4'hF; eRb = 4'hF;
        eValc = 32'h0; eValp = 32'h0; ePc = 32'h0; eStat = 3'd1;
    endtask

    task automatic modelStep(input logic rst, input logic st, input logic bu,
                             input logic rd, input logic [31:0] rdpc);
        logic [7:0]  b [6];
        int          len;
        logic [3:0]  ic;
        logic [2:0]  s;
        logic [31:0] c;
        if (rst) begin
            mpc = RESET_PC; mmode = S_RUN; modelBubble();
        end else if (rd) begin
            mpc = rdpc; mmode = S_RUN; modelBubble();
        end else if (st) begin
            if (bu) modelBubble();
        end else if (bu || mmode != S_RUN) begin
            modelBubble();
        end else begin
            for (int k = 0; k < 6; k++) b[k] = rdByte(mpc + 32'(k));
            ic  = b[0][7:4];
            len = lenTable[ic];
            s   = 3'd1;
            if (len == 0) begin
                s = 3'd4; len = 1;
            end else if (ic == 4'h0) begin
                s = 3'd2;
            end
            if (longint'({32'b0, mpc}) + longint'(len) > longint'(MEM_SIZE)) s = 3'd3;
            if (len == 6)      c = {b[5], b[4], b[3], b[2]};
            else if (len == 5) c = {b[4], b[3], b[2], b[1]};
            else               c = 32'h0;
            eValid = 1'b1; eIcode = ic; eIfun = b[0][3:0];
            eRa    = (len == 2 || len == 6) ? b[1][7:4] : 4'hF;
            eRb    = (len == 2 || len == 6) ? b[1][3:0] : 4'hF;
            eValc  = c; eValp = mpc + 32'(len); ePc = mpc; eStat = s;
            mpc    = (ic == 4'h7 || ic == 4'h8) ? c : eValp;
            if (s == 3'd3 || s == 3'd4) mmode = S_ERR;
            else if (s == 3'd2)         mmode = S_HALT;
            else if (ic == 4'h9)        mmode = S_WAIT_RET;
            else                        mmode = S_RUN;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic bu,
                                 input logic rd, input logic [31:0] rdpc);
        reset = rst; stall = st; bubble = bu; redirect = rd; redirect_pc = rdpc;
        @(posedge clk);
        modelStep(rst, st, bu, rd, rdpc);
        #1;
        reset = 1'b0; stall = 1'b0; bubble = 1'b0; redirect = 1'b0;
        checkOutput("iaddr", iaddr, mpc);
        checkOutput("fetch_state", 32'(fetch_state), 32'(mmode));
        checkOutput("d_valid", 32'(d_valid), 32'(eValid));
        checkOutput("d_icode", 32'(d_icode), 32'(eIcode));
        checkOutput("d_ifun", 32'(d_ifun), 32'(eIfun));
        checkOutput("d_rA", 32'(d_rA), 32'(eRa));
        checkOutput("d_rB", 32'(d_rB), 32'(eRb));
        checkOutput("d_valC", d_valC, eValc);
        checkOutput("d_valP", d_valP, eValp);
        checkOutput("d_pc", d_pc, ePc);
        checkOutput("d_stat", 32'(d_stat), 32'(eStat));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h10;

        // irmovl at reset PC
        putBytes(0, 48'h12345678F230, 6);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("rst_valid", 32'(d_valid), 32'h0);
        checkOutput("rst_stat", 32'(d_stat), 32'h1);
        step(1);
        checkOutput("irmovl_icode", 32'(d_icode), 32'h3);
        checkOutput("irmovl_rB", 32'(d_rB), 32'h2);
        checkOutput("irmovl_valC", d_valC, 32'h12345678);
        checkOutput("irmovl_valP", d_valP, 32'h6);
        checkOutput("irmovl_next", iaddr, 32'h6);

        // jmp prediction
        putBytes(0, 48'h000000002070, 5);
        applyStimulus(1, 0, 0, 0, 32'h0);
        step(1);
        checkOutput("jmp_valC", d_valC, 32'h20);
        checkOutput("jmp_valP", d_valP, 32'h5);
        checkOutput("jmp_next", iaddr, 32'h20);

        // ret waits for redirect
        putBytes(8, 48'h90, 1);
        applyStimulus(0, 0, 0, 1, 32'h8);
        step(1);
        checkOutput("ret_state", 32'(fetch_state), 32'(S_WAIT_RET));
        step(3);
        checkOutput("ret_bubble", 32'(d_valid), 32'h0);
        checkOutput("ret_iaddr", iaddr, 32'h9);
        applyStimulus(0, 0, 0, 1, 32'h40);
        checkOutput("ret_redir", iaddr, 32'h40);
        step(1);
        checkOutput("ret_dpc", d_pc, 32'h40);

        // illegal icode, then halt
        putBytes(4, 48'hF0, 1);
        applyStimulus(0, 0, 0, 1, 32'h4);
        step(1);
        checkOutput("ins_stat", 32'(d_stat), 32'h4);
        checkOutput("ins_state", 32'(fetch_state), 32'(S_ERR));
        step(2);
        checkOutput("ins_bubble", 32'(d_valid), 32'h0);
        checkOutput("ins_iaddr", iaddr, 32'h5);
        putBytes(32'h60, 48'h00, 1);
        applyStimulus(0, 0, 0, 1, 32'h60);
        step(1);
        checkOutput("hlt_stat", 32'(d_stat), 32'h2);
        checkOutput("hlt_state", 32'(fetch_state), 32'(S_HALT));
        step(2);

        // end-of-memory boundary
        putBytes(MEM_SIZE - 4, 48'h5678F230, 4);
        applyStimulus(0, 0, 0, 1, 32'(MEM_SIZE - 4));
        step(1);
        checkOutput("adr_stat", 32'(d_stat), 32'h3);
        checkOutput("adr_state", 32'(fetch_state), 32'(S_ERR));
        putBytes(MEM_SIZE - 6, 48'h12345678F230, 6);
        applyStimulus(0, 0, 0, 1, 32'(MEM_SIZE - 6));
        step(1);
        checkOutput("edge_stat", 32'(d_stat), 32'h1);

        // stall / bubble / redirect priority over a run of NOPs
        putBytes(32'h100, 48'h101010101010, 6);
        applyStimulus(0, 0, 0, 1, 32'h100);
        step(2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("stall_dpc", d_pc, 32'h101);
        checkOutput("stall_iaddr", iaddr, 32'h102);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("stbub_valid", 32'(d_valid), 32'h0);
        checkOutput("stbub_iaddr", iaddr, 32'h102);
        applyStimulus(0, 1, 0, 1, 32'h200);
        checkOutput("redir_stall", iaddr, 32'h200);

        // randomized memory contents and control
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = 8'($urandom);
            if ($urandom_range(0, 7) != 0) mem[i][7:4] = 4'($urandom_range(1, 11));
        end
        applyStimulus(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic [31:0] tgt;
            r   = int'($urandom_range(0, 99));
            tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC
                                               : 32'($urandom_range(0, MEM_SIZE + 8));
            applyStimulus(r == 0, (r >= 7 && r < 17) || r == 99,
                          (r >= 14 && r < 22), (r >= 1 && r < 7), tgt);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
